// File: rtl/arb2way_8bit_stage_pkg.sv
// Shared definitions for the two-way arbitrating output stage.
package arb2way_8bit_stage_pkg;

    // Default payload width of both producer channels and the output register.
    localparam int unsigned WIDTH_DEFAULT = 8;

    // Channel index. It is used for the mux address, out_src and last_grant.
    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } ch_e;

endpackage

// File: rtl/arb2way_8bit_stage_if.sv
// Handshake bundle: two producer channels in, one registered consumer channel out.
interface arb2way_8bit_stage_if
    import arb2way_8bit_stage_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
);

    logic             in0_valid;
    logic [WIDTH-1:0] in0_data;
    logic             in0_ready;
    logic             in1_valid;
    logic [WIDTH-1:0] in1_data;
    logic             in1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_ready;

    // Environment side: drives the producers and the consumer's ready.
    modport master (
        output in0_valid, in0_data, in1_valid, in1_data, out_ready,
        input  in0_ready, in1_ready, out_valid, out_data, out_src
    );

    // Stage side.
    modport slave (
        input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
        output in0_ready, in1_ready, out_valid, out_data, out_src
    );

endinterface

// File: rtl/arb2way_8bit_stage_mux2way_8bit.sv
// Existing two-way data select cell: address 0 picks in0, address 1 picks in1.
module mux2way_8bit
    import arb2way_8bit_stage_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             address,
    output logic [WIDTH-1:0] mux_out
);

    // Pure combinational select.
    always_comb begin
        mux_out = (address == CH1) ? in1 : in0;
    end

endmodule

// File: rtl/arb2way_8bit_stage.sv
// Round-robin arbiter in front of a one-entry output register with its own handshake.
module arb2way_8bit_stage
    import arb2way_8bit_stage_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    arb2way_8bit_stage_if.slave  bus
);

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    ch_e              out_src_q;
    ch_e              last_grant;

    logic             load;
    logic             grant;
    ch_e              sel;
    logic [WIDTH-1:0] mux_out;
    logic             in0_ready;
    logic             in1_ready;

    mux2way_8bit #(
        .WIDTH (WIDTH)
    ) u_mux (
        .in0     (bus.in0_data),
        .in1     (bus.in1_data),
        .address (sel),
        .mux_out (mux_out)
    );

    // Arbitration: a lone requester wins outright. A tie goes to the channel not granted last.
    always_comb begin
        load      = ~out_valid_q | bus.out_ready;
        grant     = bus.in0_valid | bus.in1_valid;
        sel       = CH0;
        if (bus.in0_valid && bus.in1_valid) begin
            sel = (last_grant == CH0) ? CH1 : CH0;
        end else if (bus.in1_valid) begin
            sel = CH1;
        end
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        if (!reset && load && grant) begin
            in0_ready = (sel == CH0);
            in1_ready = (sel == CH1);
        end
    end

    // Output register and round-robin pointer. The pointer moves only when a byte is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= CH0;
            last_grant  <= CH1;
        end else if (load) begin
            if (grant) begin
                out_valid_q <= 1'b1;
                out_data_q  <= mux_out;
                out_src_q   <= sel;
                last_grant  <= sel;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in0_ready = in0_ready;
    assign bus.in1_ready = in1_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_arb2way_8bit_stage.sv
// Directed bench for the two-way round-robin output stage.
module tb_arb2way_8bit_stage;

    logic clk;
    logic reset;
    int   passed;
    int   total;

    arb2way_8bit_stage_if #(.WIDTH(8)) bus ();

    arb2way_8bit_stage #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [7:0] d0,
                         input logic v1, input logic [7:0] d1, input logic ordy);
        bus.in0_valid = v0;
        bus.in0_data  = d0;
        bus.in1_valid = v1;
        bus.in1_data  = d1;
        bus.out_ready = ordy;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if ({bus.in0_ready, bus.in1_ready} !== 2'b00)
                $display("FAIL reset_ready: got %b expected 00", {bus.in0_ready, bus.in1_ready});
            else passed++;
            tick();
            total++;
            if ({bus.out_valid, bus.out_data, bus.out_src} !== 10'h000)
                $display("FAIL reset_out: got v=%b d=%h s=%b expected v=0 d=00 s=0",
                         bus.out_valid, bus.out_data, bus.out_src);
            else passed++;
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        drive(1'b0, 8'h00, 1'b1, 8'hA5, 1'b1);
        #1;
        total++;
        if ({bus.in0_ready, bus.in1_ready} !== 2'b01)
            $display("FAIL single_ready: got %b expected 01", {bus.in0_ready, bus.in1_ready});
        else passed++;
        tick();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        total++;
        if ({bus.out_valid, bus.out_data, bus.out_src} !== {1'b1, 8'hA5, 1'b1})
            $display("FAIL single_out: got v=%b d=%h s=%b expected v=1 d=a5 s=1",
                     bus.out_valid, bus.out_data, bus.out_src);
        else passed++;
        tick();
        total++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL single_drain: got %b expected 0", bus.out_valid);
        else passed++;
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'h11, 8'h22};
        logic       exp_s [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        // Grant channel 0 first so that reset has to restore the pointer.
        drive(1'b1, 8'h99, 1'b0, 8'h00, 1'b1);
        tick();
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        tick();
        reset = 1'b0;
        drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
        for (int c = 0; c < 4; c++) begin
            #1;
            total++;
            if ({bus.in0_ready, bus.in1_ready} !== {~exp_s[c], exp_s[c]})
                $display("FAIL rr_ready%0d: got %b expected %b", c,
                         {bus.in0_ready, bus.in1_ready}, {~exp_s[c], exp_s[c]});
            else passed++;
            tick();
            total++;
            if ({bus.out_valid, bus.out_data, bus.out_src} !== {1'b1, exp_d[c], exp_s[c]})
                $display("FAIL rr_out%0d: got v=%b d=%h s=%b expected v=1 d=%h s=%b", c,
                         bus.out_valid, bus.out_data, bus.out_src, exp_d[c], exp_s[c]);
            else passed++;
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        tick();
    endtask

    task automatic test_backpressure();
        drive(1'b1, 8'h33, 1'b0, 8'h00, 1'b1);
        tick();
        drive(1'b1, 8'h44, 1'b0, 8'h00, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (bus.in0_ready !== 1'b0)
                $display("FAIL bp_ready%0d: got %b expected 0", c, bus.in0_ready);
            else passed++;
            tick();
            total++;
            if ({bus.out_valid, bus.out_data} !== {1'b1, 8'h33})
                $display("FAIL bp_hold%0d: got v=%b d=%h expected v=1 d=33", c,
                         bus.out_valid, bus.out_data);
            else passed++;
        end
        bus.out_ready = 1'b1;
        #1;
        total++;
        if (bus.in0_ready !== 1'b1)
            $display("FAIL bp_release_ready: got %b expected 1", bus.in0_ready);
        else passed++;
        tick();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        total++;
        if ({bus.out_valid, bus.out_data, bus.out_src} !== {1'b1, 8'h44, 1'b0})
            $display("FAIL bp_refill: got v=%b d=%h s=%b expected v=1 d=44 s=0",
                     bus.out_valid, bus.out_data, bus.out_src);
        else passed++;
        tick();
    endtask

    task automatic test_stall_priority();
        drive(1'b1, 8'h55, 1'b0, 8'h00, 1'b1);
        tick();
        drive(1'b1, 8'h66, 1'b1, 8'h77, 1'b0);
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if ({bus.in0_ready, bus.in1_ready} !== 2'b00)
                $display("FAIL stall_ready%0d: got %b expected 00", c,
                         {bus.in0_ready, bus.in1_ready});
            else passed++;
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        total++;
        if ({bus.in0_ready, bus.in1_ready} !== 2'b01)
            $display("FAIL stall_release_ready: got %b expected 01",
                     {bus.in0_ready, bus.in1_ready});
        else passed++;
        tick();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        total++;
        if ({bus.out_valid, bus.out_data, bus.out_src} !== {1'b1, 8'h77, 1'b1})
            $display("FAIL stall_winner: got v=%b d=%h s=%b expected v=1 d=77 s=1",
                     bus.out_valid, bus.out_data, bus.out_src);
        else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 8'h00, 1'b1, 8'h5A, 1'b1);
        tick();
        total++;
        if ({bus.out_valid, bus.out_data, bus.out_src} !== {1'b1, 8'h5A, 1'b1})
            $display("FAIL mid_load: got v=%b d=%h s=%b expected v=1 d=5a s=1",
                     bus.out_valid, bus.out_data, bus.out_src);
        else passed++;
        reset = 1'b1;
        drive(1'b1, 8'hC0, 1'b1, 8'hC1, 1'b1);
        #1;
        total++;
        if ({bus.in0_ready, bus.in1_ready} !== 2'b00)
            $display("FAIL mid_reset_ready: got %b expected 00", {bus.in0_ready, bus.in1_ready});
        else passed++;
        tick();
        reset = 1'b0;
        total++;
        if ({bus.out_valid, bus.out_data, bus.out_src} !== 10'h000)
            $display("FAIL mid_reset_out: got v=%b d=%h s=%b expected v=0 d=00 s=0",
                     bus.out_valid, bus.out_data, bus.out_src);
        else passed++;
        #1;
        total++;
        if ({bus.in0_ready, bus.in1_ready} !== 2'b10)
            $display("FAIL mid_post_ready: got %b expected 10", {bus.in0_ready, bus.in1_ready});
        else passed++;
        tick();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        total++;
        if ({bus.out_valid, bus.out_data, bus.out_src} !== {1'b1, 8'hC0, 1'b0})
            $display("FAIL mid_post_out: got v=%b d=%h s=%b expected v=1 d=c0 s=0",
                     bus.out_valid, bus.out_data, bus.out_src);
        else passed++;
        tick();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_stall_priority();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
